// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with false-start and framing checks
// Optional parity bit after the data: define UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW     = $clog2(OVERSAMPLE);
  localparam int BCW     = $clog2(DATA_BITS + 1);

  localparam logic [DCW-1:0] DIV_LAST     = DCW'(DIV - 1);
  localparam logic [SCW-1:0] SC_MID       = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST      = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BC_STOP_LAST = BCW'(STOP_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx_param: unsupported parameter combination");
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  logic rxd_m, rxd_s;
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  logic [DCW-1:0] div_cnt;
  logic           tick;
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DCW'(1);
  end

  state_t               state, state_n;
  logic [SCW-1:0]       sample_cnt, sample_n;
  logic [BCW-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 stop_low, stop_low_n;
  logic                 armed, armed_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n, ferr_n, perr_n;
  logic                 sample_last;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
`endif

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      stop_low   <= 1'b0;
      armed      <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      shreg      <= shreg_n;
      stop_low   <= stop_low_n;
      armed      <= armed_n;
      rx_data    <= data_n;
      rx_valid   <= valid_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    sample_n    = sample_cnt;
    bit_n       = bit_cnt;
    shreg_n     = shreg;
    stop_low_n  = stop_low;
    armed_n     = armed;
    data_n      = rx_data;
    valid_n     = 1'b0;
    ferr_n      = frame_err;
    perr_n      = parity_err;
`ifdef UART_RX_PARITY_EN
    par_bad_n   = par_bad;
`endif
    sample_last = (sample_cnt == SC_LAST);

    if (tick) begin
      unique case (state)
        S_IDLE: begin
          // After a framing error the line must be seen high before a new start is trusted.
          if (rxd_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n  = S_START;
            sample_n = '0;
          end
        end

        S_START: begin
          if (sample_cnt == SC_MID) begin
            sample_n = '0;
            if (rxd_s) begin
              state_n = S_IDLE;
            end else begin
              state_n = S_DATA;
              bit_n   = '0;
            end
          end else begin
            sample_n = sample_cnt + SCW'(1);
          end
        end

        S_DATA: begin
          if (sample_last) begin
            sample_n = '0;
            shreg_n  = {rxd_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == BC_DATA_LAST) begin
              bit_n      = '0;
              stop_low_n = 1'b0;
`ifdef UART_RX_PARITY_EN
              state_n    = S_PARITY;
`else
              state_n    = S_STOP;
`endif
            end else begin
              bit_n = bit_cnt + BCW'(1);
            end
          end else begin
            sample_n = sample_cnt + SCW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (sample_last) begin
            sample_n  = '0;
            par_bad_n = (^shreg) ^ rxd_s ^ PAR_ODD_BIT;
            state_n   = S_STOP;
          end else begin
            sample_n = sample_cnt + SCW'(1);
          end
        end
`endif

        S_STOP: begin
          if (sample_last) begin
            sample_n = '0;
            if (bit_cnt == BC_STOP_LAST) begin
              state_n = S_IDLE;
              valid_n = 1'b1;
              data_n  = shreg;
              ferr_n  = stop_low | ~rxd_s;
              armed_n = ~(stop_low | ~rxd_s);
`ifdef UART_RX_PARITY_EN
              perr_n  = par_bad;
`else
              perr_n  = 1'b0;
`endif
            end else begin
              bit_n      = bit_cnt + BCW'(1);
              stop_low_n = stop_low | ~rxd_s;
            end
          end else begin
            sample_n = sample_cnt + SCW'(1);
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_param;

  localparam int CLK_FREQ   = 1600;
  localparam int BAUD_RATE  = 100;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_T      = 16;

  logic       clk_fpga = 1'b0;
  logic       reset    = 1'b1;
  logic       rxd      = 1'b1;
  logic       rxd2     = 1'b1;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, frame_err, parity_err, busy;
  logic       rx_valid2, frame_err2, parity_err2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  int         v1_cnt = 0;
  logic [7:0] v1_data;
  logic       v1_fe, v1_pe;
  int         v2_cnt = 0;
  logic [7:0] v2_data [0:3];
  logic       v2_err  [0:3];

`ifdef UART_RX_PARITY_EN
  logic par_force = 1'b0;
  logic par_val   = 1'b0;
`endif

  always #5 clk_fpga = ~clk_fpga;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk_fpga(clk_fpga), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE),
    .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)
  ) dut2 (
    .clk_fpga(clk_fpga), .reset(reset), .rxd(rxd2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .frame_err(frame_err2),
    .parity_err(parity_err2), .busy(busy2)
  );

  always @(negedge clk_fpga) begin
    if (rx_valid === 1'b1) begin
      v1_cnt  = v1_cnt + 1;
      v1_data = rx_data;
      v1_fe   = frame_err;
      v1_pe   = parity_err;
    end
    if (rx_valid2 === 1'b1) begin
      if (v2_cnt < 4) begin
        v2_data[v2_cnt[1:0]] = rx_data2;
        v2_err[v2_cnt[1:0]]  = frame_err2 | parity_err2;
      end
      v2_cnt = v2_cnt + 1;
    end
  end

  task automatic drive_bit(input int line, input logic v);
    if (line == 0) rxd = v;
    else           rxd2 = v;
    repeat (BIT_T) @(negedge clk_fpga);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input int n_stop, input logic stop_v);
    drive_bit(line, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(line, par_force ? par_val : ^d);
`endif
    for (int i = 0; i < n_stop; i++) drive_bit(line, stop_v);
  endtask

  task automatic wait_v1(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (v1_cnt >= target) break;
      @(negedge clk_fpga);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rxd   = 1'b1;
    rxd2  = 1'b1;
    repeat (3) @(negedge clk_fpga);
    if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data: got %h expected 00", rx_data); n_fail++; end
    n_checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); n_fail++; end
    n_checks++;
    if (frame_err !== 1'b0) begin $display("FAIL reset_frame_err: got %b expected 0", frame_err); n_fail++; end
    n_checks++;
    if (parity_err !== 1'b0) begin $display("FAIL reset_parity_err: got %b expected 0", parity_err); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    reset = 1'b0;
    repeat (5) @(negedge clk_fpga);
    if (busy2 !== 1'b0) begin $display("FAIL reset_busy2_idle: got %b expected 0", busy2); n_fail++; end
    n_checks++;
  endtask

  task automatic test_8n1;
    int base;
    base = v1_cnt;
    send_frame(0, 8'hA5, 1, 1'b1);
    wait_v1(base + 1, 40);
    repeat (20) @(negedge clk_fpga);
    if (v1_cnt !== base + 1) begin $display("FAIL 8n1_pulses: got %0d expected %0d", v1_cnt - base, 1); n_fail++; end
    n_checks++;
    if (v1_data !== 8'hA5) begin $display("FAIL 8n1_data: got %h expected a5", v1_data); n_fail++; end
    n_checks++;
    if (v1_fe !== 1'b0) begin $display("FAIL 8n1_frame_err: got %b expected 0", v1_fe); n_fail++; end
    n_checks++;
    if (v1_pe !== 1'b0) begin $display("FAIL 8n1_parity_err: got %b expected 0", v1_pe); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL 8n1_busy_after: got %b expected 0", busy); n_fail++; end
    n_checks++;
  endtask

  task automatic test_false_start;
    int base;
    base = v1_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk_fpga);
    if (busy !== 1'b1) begin $display("FAIL false_start_busy_rise: got %b expected 1", busy); n_fail++; end
    n_checks++;
    rxd = 1'b1;
    repeat (8) @(negedge clk_fpga);
    if (busy !== 1'b0) begin $display("FAIL false_start_busy_fall: got %b expected 0", busy); n_fail++; end
    n_checks++;
    repeat (30) @(negedge clk_fpga);
    if (v1_cnt !== base) begin $display("FAIL false_start_no_valid: got %0d pulses expected 0", v1_cnt - base); n_fail++; end
    n_checks++;
    send_frame(0, 8'h3C, 1, 1'b1);
    wait_v1(base + 1, 40);
    if (v1_cnt !== base + 1) begin $display("FAIL false_start_next_pulses: got %0d expected 1", v1_cnt - base); n_fail++; end
    n_checks++;
    if (v1_data !== 8'h3C) begin $display("FAIL false_start_next_data: got %h expected 3c", v1_data); n_fail++; end
    n_checks++;
    if (v1_fe !== 1'b0) begin $display("FAIL false_start_next_frame_err: got %b expected 0", v1_fe); n_fail++; end
    n_checks++;
  endtask

  task automatic test_framing;
    int base;
    base = v1_cnt;
    send_frame(0, 8'h3C, 1, 1'b0);
    repeat (20) @(negedge clk_fpga);
    if (busy !== 1'b0) begin $display("FAIL framing_busy_while_low: got %b expected 0", busy); n_fail++; end
    n_checks++;
    repeat (20) @(negedge clk_fpga);
    if (v1_cnt !== base + 1) begin $display("FAIL framing_pulses: got %0d expected 1", v1_cnt - base); n_fail++; end
    n_checks++;
    if (v1_data !== 8'h3C) begin $display("FAIL framing_data: got %h expected 3c", v1_data); n_fail++; end
    n_checks++;
    if (v1_fe !== 1'b1) begin $display("FAIL framing_frame_err: got %b expected 1", v1_fe); n_fail++; end
    n_checks++;
    rxd = 1'b1;
    repeat (32) @(negedge clk_fpga);
    if (v1_cnt !== base + 1) begin $display("FAIL framing_no_accept_low: got %0d expected 1", v1_cnt - base); n_fail++; end
    n_checks++;
    send_frame(0, 8'h81, 1, 1'b1);
    wait_v1(base + 2, 40);
    if (v1_cnt !== base + 2) begin $display("FAIL framing_recover_pulses: got %0d expected 2", v1_cnt - base); n_fail++; end
    n_checks++;
    if (v1_data !== 8'h81) begin $display("FAIL framing_recover_data: got %h expected 81", v1_data); n_fail++; end
    n_checks++;
    if (v1_fe !== 1'b0) begin $display("FAIL framing_recover_frame_err: got %b expected 0", v1_fe); n_fail++; end
    n_checks++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int base;
    base      = v1_cnt;
    par_force = 1'b1;
    par_val   = 1'b0;
    send_frame(0, 8'h07, 1, 1'b1);
    wait_v1(base + 1, 40);
    if (v1_pe !== 1'b1) begin $display("FAIL parity_bad_err: got %b expected 1", v1_pe); n_fail++; end
    n_checks++;
    if (v1_data !== 8'h07) begin $display("FAIL parity_bad_data: got %h expected 07", v1_data); n_fail++; end
    n_checks++;
    par_val = 1'b1;
    send_frame(0, 8'h07, 1, 1'b1);
    wait_v1(base + 2, 40);
    if (v1_cnt !== base + 2) begin $display("FAIL parity_pulses: got %0d expected 2", v1_cnt - base); n_fail++; end
    n_checks++;
    if (v1_pe !== 1'b0) begin $display("FAIL parity_good_err: got %b expected 0", v1_pe); n_fail++; end
    n_checks++;
    par_force = 1'b0;
    repeat (20) @(negedge clk_fpga);
  endtask
`endif

  task automatic test_reset_mid_frame;
    int base;
    base = v1_cnt;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    rxd = 1'b0;
    repeat (8) @(negedge clk_fpga);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(negedge clk_fpga);
    if (rx_data !== 8'h00) begin $display("FAIL midreset_rx_data: got %h expected 00", rx_data); n_fail++; end
    n_checks++;
    if (rx_valid !== 1'b0) begin $display("FAIL midreset_rx_valid: got %b expected 0", rx_valid); n_fail++; end
    n_checks++;
    if (frame_err !== 1'b0) begin $display("FAIL midreset_frame_err: got %b expected 0", frame_err); n_fail++; end
    n_checks++;
    if (parity_err !== 1'b0) begin $display("FAIL midreset_parity_err: got %b expected 0", parity_err); n_fail++; end
    n_checks++;
    if (busy !== 1'b0) begin $display("FAIL midreset_busy: got %b expected 0", busy); n_fail++; end
    n_checks++;
    reset = 1'b0;
    repeat (40) @(negedge clk_fpga);
    if (v1_cnt !== base) begin $display("FAIL midreset_no_valid: got %0d pulses expected 0", v1_cnt - base); n_fail++; end
    n_checks++;
    send_frame(0, 8'h55, 1, 1'b1);
    wait_v1(base + 1, 40);
    if (v1_cnt !== base + 1) begin $display("FAIL midreset_next_pulses: got %0d expected 1", v1_cnt - base); n_fail++; end
    n_checks++;
    if (v1_data !== 8'h55) begin $display("FAIL midreset_next_data: got %h expected 55", v1_data); n_fail++; end
    n_checks++;
  endtask

  task automatic test_back_to_back;
    int base, b1;
    base = v2_cnt;
    b1   = base + 1;
    send_frame(1, 8'h00, 2, 1'b1);
    send_frame(1, 8'hFF, 2, 1'b1);
    rxd2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (v2_cnt >= base + 2) break;
      @(negedge clk_fpga);
    end
    repeat (10) @(negedge clk_fpga);
    if (v2_cnt !== base + 2) begin $display("FAIL b2b_pulses: got %0d expected 2", v2_cnt - base); n_fail++; end
    n_checks++;
    if (v2_data[base[1:0]] !== 8'h00) begin $display("FAIL b2b_first_data: got %h expected 00", v2_data[base[1:0]]); n_fail++; end
    n_checks++;
    if (v2_err[base[1:0]] !== 1'b0) begin $display("FAIL b2b_first_err: got %b expected 0", v2_err[base[1:0]]); n_fail++; end
    n_checks++;
    if (v2_data[b1[1:0]] !== 8'hFF) begin $display("FAIL b2b_second_data: got %h expected ff", v2_data[b1[1:0]]); n_fail++; end
    n_checks++;
    if (v2_err[b1[1:0]] !== 1'b0) begin $display("FAIL b2b_second_err: got %b expected 0", v2_err[b1[1:0]]); n_fail++; end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_false_start();
    test_framing();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, next generation of the fixed 8N1 receiver in the FPGA serial path. It supports configurable data width, oversampling, stop bits and an optional parity bit. It adds input synchronisation, false-start rejection and framing-error detection, and emits a one-cycle `rx_valid` strobe per completed frame. It sits between the board `rxd` pin and downstream consumers such as the LED/7-segment display logic.

## Interface
- `CLK_FREQ`, 50000000, clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bit/s.
- `OVERSAMPLE`, 16, ticks per bit; even, ≥4.
- `DATA_BITS`, 8, data bits per frame; 5..9.
- `STOP_BITS`, 1, stop bits; 1 or 2.
- `PARITY_ODD`, 0, 1 selects odd parity, 0 selects even parity; used only with `UART_RX_PARITY_EN`.
- `clk_fpga`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `rxd`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  DATA_BITS  last received word, LSB first on the line.
- `rx_valid`  out  1  one-cycle pulse per completed frame.
- `frame_err`  out  1  a stop bit of the last frame sampled low.
- `parity_err`  out  1  parity mismatch on the last frame.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Synchroniser: `rxd` passes through 2 flops, both reset to 1. The output `rxd_s` is the only line value used.
- Tick generator: `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)`, truncated, minimum 1. The counter runs 0..DIV-1 and `tick` is high for the one cycle where the counter = DIV-1.
- The FSM and all counters advance only on `tick`.
- `sample_cnt` width is clog2(OVERSAMPLE). `bit_cnt` width is clog2(DATA_BITS+1).
- IDLE: when `rxd_s`=0 and `armed`=1, go to START with `sample_cnt`=0.
- START: increment `sample_cnt`. When `sample_cnt`=OVERSAMPLE/2-1 (mid start bit):
  - if `rxd_s`=1, this is a false start; return to IDLE with no outputs changed;
  - otherwise go to DATA with `sample_cnt`=0 and `bit_cnt`=0.
- DATA: when `sample_cnt`=OVERSAMPLE-1:
  - shift `rxd_s` into the MSB of the shift register (LSB-first reception);
  - clear `sample_cnt` and increment `bit_cnt`;
  - after DATA_BITS samples, go to PARITY (macro defined) or STOP.
- PARITY: sample one bit at `sample_cnt`=OVERSAMPLE-1. The error is XOR of data bits, the parity bit and PARITY_ODD.
- STOP: sample STOP_BITS bits, each at `sample_cnt`=OVERSAMPLE-1. Any low sample sets the frame error. After the last stop sample, on the same tick:
  - load `rx_data`, `frame_err` and `parity_err`;
  - pulse `rx_valid`;
  - go to IDLE.
- Every completed frame pulses `rx_valid`, errored or not. The error flags qualify the frame and hold until the next completed frame.
- Break/framing recovery: after a frame with `frame_err`=1, `armed`=0. `armed` returns to 1 on the first tick in IDLE where `rxd_s`=1. `armed` resets to 1.
- Reset mid-frame: abort with no `rx_valid`. All state returns to reset values.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, FSM=IDLE, tick counter=0, synchroniser=1.
- Let t0 be the tick on which IDLE detects the start bit. The start bit is checked on tick t0+OVERSAMPLE/2.
- Data bit i (0-based) is sampled on tick t0+OVERSAMPLE/2+OVERSAMPLE·(i+1).
- The final stop sample is on tick t0+OVERSAMPLE/2+OVERSAMPLE·(DATA_BITS+P+STOP_BITS), where P=1 with the macro defined, else 0.
- `rx_valid` is high for the clock cycle following that tick's edge. `rx_data` and the flags are valid in the same cycle and stable afterwards.
- Line-to-detect latency: 2 cycles of synchroniser plus up to DIV cycles of tick phase.
- A new start bit is accepted on the first tick after returning to IDLE. Back-to-back frames with zero idle gap are received.
- `busy` rises with the transition into START and falls with the transition into IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state is present and the frame carries one parity bit after the data;
  - `parity_err` is computed per frame.
- `UART_RX_PARITY_EN` not defined:
  - there is no PARITY state, so the frame is start + data + stop;
  - `parity_err` is tied to 0 and PARITY_ODD is ignored.

## Test plan
Bench parameters: CLK_FREQ=1600, BAUD_RATE=100, OVERSAMPLE=16, so DIV=1.
- 8N1, send 0xA5 → exactly one `rx_valid` pulse; `rx_data`=0xA5; `frame_err`=0; `parity_err`=0; `busy` low afterwards.
- Drive `rxd` low for 4 bit-ticks, then high → no `rx_valid`; `busy` returns to 0 within 8 ticks; a following 0x3C is received correctly.
- Send 0x3C with the stop bit low and hold the line low for 40 ticks, then idle high, then send 0x81 → first pulse has `rx_data`=0x3C and `frame_err`=1; no frame is accepted while the line is low; second pulse has `rx_data`=0x81 and `frame_err`=0.
- Macro defined, PARITY_ODD=0: send 0x07 with parity bit 0 → `parity_err`=1. Send 0x07 with parity bit 1 → `parity_err`=0.
- Assert `reset` during data bit 3 of 0xF0 → all outputs 0 and no `rx_valid`. After release, 0x55 is received correctly.
- STOP_BITS=2: send 0x00 and 0xFF back-to-back with no gap → two `rx_valid` pulses, 0x00 then 0xFF, no errors.
